// File: rtl/veri_yolu_denetleyici.sv
// CPU-side bus controller: memory, I/O, a 64-bit timer, and fault responses.
// Optional wait timeout on memory/I/O targets: define ZAMAN_ASIMI_EN.
module veri_yolu_denetleyici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_istek_i,
  input  logic        cpu_yaz_i,
  input  logic [31:0] cpu_adres_i,
  input  logic [31:0] cpu_veri_i,
  output logic        cpu_hazir_o,
  output logic [31:0] cpu_veri_o,
  output logic        cpu_hata_o,
  output logic        cpu_durdur_o,
  output logic [31:0] hedef_adres_o,
  output logic [31:0] hedef_veri_o,
  output logic        hedef_yaz_o,
  output logic        bellek_istek_o,
  input  logic        bellek_hazir_i,
  input  logic [31:0] bellek_veri_i,
  output logic        gc_istek_o,
  input  logic        gc_hazir_i,
  input  logic [31:0] gc_veri_i
);

  typedef enum logic [1:0] {
    BOSTA,
    BELLEK_BEKLE,
    GC_BEKLE,
    YANIT
  } durum_t;

  durum_t      durum, durum_d;
  logic [63:0] zaman;
  logic [31:0] adres_q, veri_q, yanit_q;
  logic        yaz_q, hata_q;
  logic        kabul, yakala, hata_d;
  logic [31:0] yanit_d;
  logic [2:0]  bolge;

  assign bolge = cpu_adres_i[30:28];

`ifdef ZAMAN_ASIMI_EN
  logic [7:0] sayac;
  logic       zaman_asimi;

  // sayac==254 marks the 255th consecutive wait cycle
  assign zaman_asimi = (sayac == 8'd254);

  always_ff @(posedge clk_i) begin
    if (rst_i || kabul) sayac <= '0;
    else if (durum == BELLEK_BEKLE || durum == GC_BEKLE)
      sayac <= sayac + 8'd1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) durum <= BOSTA;
    else       durum <= durum_d;
  end

  always_comb begin
    durum_d = durum;
    kabul   = 1'b0;
    yakala  = 1'b0;
    yanit_d = '0;
    hata_d  = 1'b0;
    case (durum)
      BOSTA: begin
        if (cpu_istek_i) begin
          kabul = 1'b1;
          case (bolge)
            3'd4: durum_d = BELLEK_BEKLE;
            3'd2: durum_d = GC_BEKLE;
            3'd3: begin
              durum_d = YANIT;
              yakala  = 1'b1;
              if (cpu_yaz_i) hata_d = 1'b1;
              else if (cpu_adres_i[2]) yanit_d = zaman[63:32];
              else yanit_d = zaman[31:0];
            end
            default: begin
              durum_d = YANIT;
              yakala  = 1'b1;
              hata_d  = 1'b1;
            end
          endcase
        end
      end
      BELLEK_BEKLE: begin
        if (bellek_hazir_i) begin
          durum_d = YANIT;
          yakala  = 1'b1;
          yanit_d = yaz_q ? 32'd0 : bellek_veri_i;
        end
`ifdef ZAMAN_ASIMI_EN
        else if (zaman_asimi) begin
          durum_d = YANIT;
          yakala  = 1'b1;
          hata_d  = 1'b1;
        end
`endif
      end
      GC_BEKLE: begin
        if (gc_hazir_i) begin
          durum_d = YANIT;
          yakala  = 1'b1;
          yanit_d = yaz_q ? 32'd0 : gc_veri_i;
        end
`ifdef ZAMAN_ASIMI_EN
        else if (zaman_asimi) begin
          durum_d = YANIT;
          yakala  = 1'b1;
          hata_d  = 1'b1;
        end
`endif
      end
      YANIT: durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zaman   <= '0;
      adres_q <= '0;
      veri_q  <= '0;
      yaz_q   <= 1'b0;
      yanit_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      zaman <= zaman + 64'd1;
      if (kabul) begin
        adres_q <= cpu_adres_i;
        veri_q  <= cpu_veri_i;
        yaz_q   <= cpu_yaz_i;
      end
      if (yakala) begin
        yanit_q <= yanit_d;
        hata_q  <= hata_d;
      end
    end
  end

  assign cpu_hazir_o    = (durum == YANIT);
  assign cpu_veri_o     = yanit_q;
  assign cpu_hata_o     = hata_q && (durum == YANIT);
  assign cpu_durdur_o   = ((durum == BOSTA) && cpu_istek_i) ||
                          (durum == BELLEK_BEKLE) ||
                          (durum == GC_BEKLE);
  assign bellek_istek_o = (durum == BELLEK_BEKLE);
  assign gc_istek_o     = (durum == GC_BEKLE);
  assign hedef_adres_o  = adres_q;
  assign hedef_veri_o   = veri_q;
  assign hedef_yaz_o    = yaz_q;

endmodule

// File: tb/tb_veri_yolu_denetleyici.sv
// Directed bench for veri_yolu_denetleyici; build with +define+ZAMAN_ASIMI_EN
// to exercise the timeout path instead of the indefinite wait.
module tb_veri_yolu_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_istek_i = 1'b0;
  logic        cpu_yaz_i = 1'b0;
  logic [31:0] cpu_adres_i = '0;
  logic [31:0] cpu_veri_i = '0;
  logic        cpu_hazir_o;
  logic [31:0] cpu_veri_o;
  logic        cpu_hata_o;
  logic        cpu_durdur_o;
  logic [31:0] hedef_adres_o;
  logic [31:0] hedef_veri_o;
  logic        hedef_yaz_o;
  logic        bellek_istek_o;
  logic        bellek_hazir_i = 1'b0;
  logic [31:0] bellek_veri_i = '0;
  logic        gc_istek_o;
  logic        gc_hazir_i = 1'b0;
  logic [31:0] gc_veri_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  veri_yolu_denetleyici dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_istek_i    (cpu_istek_i),
    .cpu_yaz_i      (cpu_yaz_i),
    .cpu_adres_i    (cpu_adres_i),
    .cpu_veri_i     (cpu_veri_i),
    .cpu_hazir_o    (cpu_hazir_o),
    .cpu_veri_o     (cpu_veri_o),
    .cpu_hata_o     (cpu_hata_o),
    .cpu_durdur_o   (cpu_durdur_o),
    .hedef_adres_o  (hedef_adres_o),
    .hedef_veri_o   (hedef_veri_o),
    .hedef_yaz_o    (hedef_yaz_o),
    .bellek_istek_o (bellek_istek_o),
    .bellek_hazir_i (bellek_hazir_i),
    .bellek_veri_i  (bellek_veri_i),
    .gc_istek_o     (gc_istek_o),
    .gc_hazir_i     (gc_hazir_i),
    .gc_veri_i      (gc_veri_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic istek(input logic yaz, input logic [31:0] adr,
                       input logic [31:0] dat);
    cpu_istek_i = 1'b1;
    cpu_yaz_i   = yaz;
    cpu_adres_i = adr;
    cpu_veri_i  = dat;
  endtask

  int n;

  initial begin
    tick();
    tick();
    chk("rst_hazir", cpu_hazir_o, 0);
    chk("rst_hata", cpu_hata_o, 0);
    chk("rst_veri", cpu_veri_o, 0);
    chk("rst_bellek_istek", bellek_istek_o, 0);
    chk("rst_gc_istek", gc_istek_o, 0);
    chk("rst_durdur0", cpu_durdur_o, 0);
    cpu_istek_i = 1'b1;
    #1;
    chk("rst_durdur1", cpu_durdur_o, 1);
    tick();
    chk("rst_ignores_istek", bellek_istek_o | gc_istek_o | cpu_hazir_o, 0);
    cpu_istek_i = 1'b0;

    // Last reset edge just passed: timer reads n in cycle n from here
    rst_i = 1'b0;
    repeat (10) tick();
    istek(1'b0, 32'h3000_0000, 32'h0);
    #1;
    chk("zaman_durdur", cpu_durdur_o, 1);
    tick();
    chk("zaman_hazir", cpu_hazir_o, 1);
    chk("zaman_veri_lo", cpu_veri_o, 10);
    chk("zaman_hata", cpu_hata_o, 0);
    chk("zaman_durdur_yanit", cpu_durdur_o, 0);
    cpu_istek_i = 1'b0;
    tick();
    chk("zaman_hazir_pulse", cpu_hazir_o, 0);

    istek(1'b0, 32'h3000_0004, 32'h0);
    tick();
    chk("zaman_hi_hazir", cpu_hazir_o, 1);
    chk("zaman_veri_hi", cpu_veri_o, 0);
    cpu_istek_i = 1'b0;
    tick();

    istek(1'b1, 32'h3000_0000, 32'h1234);
    tick();
    chk("hata_st_hazir", cpu_hazir_o, 1);
    chk("hata_st_hata", cpu_hata_o, 1);
    chk("hata_st_veri", cpu_veri_o, 0);
    chk("hata_st_istek", bellek_istek_o | gc_istek_o, 0);
    cpu_istek_i = 1'b0;
    tick();
    chk("hata_st_bitti", cpu_hazir_o, 0);

    istek(1'b0, 32'h1000_0000, 32'h0);
    tick();
    chk("hata_ld_hazir", cpu_hazir_o, 1);
    chk("hata_ld_hata", cpu_hata_o, 1);
    chk("hata_ld_veri", cpu_veri_o, 0);
    chk("hata_ld_istek", bellek_istek_o | gc_istek_o, 0);
    cpu_istek_i = 1'b0;
    tick();

    istek(1'b0, 32'h4000_0010, 32'h0);
    tick();
    cpu_istek_i = 1'b0;
    chk("bel_istek", bellek_istek_o, 1);
    chk("bel_gc_istek", gc_istek_o, 0);
    chk("bel_adres", hedef_adres_o, 32'h4000_0010);
    chk("bel_yaz", hedef_yaz_o, 0);
    chk("bel_durdur1", cpu_durdur_o, 1);
    gc_hazir_i = 1'b1;
    gc_veri_i  = 32'h1111_1111;
    tick();
    gc_hazir_i = 1'b0;
    chk("bel_gc_hazir_yok", cpu_hazir_o, 0);
    chk("bel_durdur2", cpu_durdur_o, 1);
    tick();
    chk("bel_durdur3", cpu_durdur_o, 1);
    bellek_hazir_i = 1'b1;
    bellek_veri_i  = 32'hDEAD_BEEF;
    tick();
    bellek_hazir_i = 1'b0;
    chk("bel_hazir", cpu_hazir_o, 1);
    chk("bel_veri", cpu_veri_o, 32'hDEAD_BEEF);
    chk("bel_hata", cpu_hata_o, 0);
    chk("bel_istek_dustu", bellek_istek_o, 0);
    chk("bel_durdur_yanit", cpu_durdur_o, 0);
    tick();
    chk("bel_bitti", cpu_hazir_o, 0);

    istek(1'b1, 32'h2000_0004, 32'h55);
    tick();
    cpu_istek_i = 1'b0;
    chk("gc_istek", gc_istek_o, 1);
    chk("gc_yaz", hedef_yaz_o, 1);
    chk("gc_hveri", hedef_veri_o, 32'h55);
    chk("gc_hadres", hedef_adres_o, 32'h2000_0004);
    chk("gc_bel_istek", bellek_istek_o, 0);
    bellek_hazir_i = 1'b1;
    tick();
    bellek_hazir_i = 1'b0;
    chk("gc_bel_hazir_yok", gc_istek_o, 1);
    chk("gc_bekle_hazir", cpu_hazir_o, 0);
    chk("gc_bel_istek2", bellek_istek_o, 0);
    gc_hazir_i = 1'b1;
    gc_veri_i  = 32'hAAAA_AAAA;
    tick();
    gc_hazir_i = 1'b0;
    chk("gc_st_hazir", cpu_hazir_o, 1);
    chk("gc_st_veri", cpu_veri_o, 0);
    chk("gc_st_hata", cpu_hata_o, 0);
    tick();

    istek(1'b0, 32'h2000_0008, 32'h0);
    tick();
    cpu_istek_i = 1'b0;
    gc_hazir_i  = 1'b1;
    gc_veri_i   = 32'h1234_5678;
    tick();
    gc_hazir_i = 1'b0;
    chk("gc_ld_hazir", cpu_hazir_o, 1);
    chk("gc_ld_veri", cpu_veri_o, 32'h1234_5678);
    tick();

    istek(1'b0, 32'h4000_0000, 32'h0);
    tick();
    cpu_istek_i = 1'b0;
    chk("rb_istek", bellek_istek_o, 1);
    rst_i = 1'b1;
    tick();
    chk("rb_istek_dustu", bellek_istek_o, 0);
    chk("rb_hazir", cpu_hazir_o, 0);
    chk("rb_veri", cpu_veri_o, 0);
    rst_i = 1'b0;
    tick();
    chk("rb_hazir2", cpu_hazir_o, 0);
    chk("rb_istek2", bellek_istek_o, 0);
    istek(1'b0, 32'h4000_0020, 32'h0);
    tick();
    cpu_istek_i    = 1'b0;
    bellek_hazir_i = 1'b1;
    bellek_veri_i  = 32'hCAFE_F00D;
    tick();
    bellek_hazir_i = 1'b0;
    chk("rb_sonra_hazir", cpu_hazir_o, 1);
    chk("rb_sonra_veri", cpu_veri_o, 32'hCAFE_F00D);
    tick();

    istek(1'b0, 32'h4000_0040, 32'h0);
    tick();
    cpu_istek_i = 1'b0;
    n = 0;
`ifdef ZAMAN_ASIMI_EN
    while (bellek_istek_o && n < 300) begin
      n++;
      tick();
    end
    chk("za_bekleme", n, 255);
    chk("za_hazir", cpu_hazir_o, 1);
    chk("za_hata", cpu_hata_o, 1);
    chk("za_veri", cpu_veri_o, 0);
    chk("za_istek", bellek_istek_o, 0);
`else
    while (bellek_istek_o && !cpu_hazir_o && n < 300) begin
      n++;
      tick();
    end
    chk("sonsuz_bekleme", n, 300);
    bellek_hazir_i = 1'b1;
    bellek_veri_i  = 32'h0BAD_CAFE;
    tick();
    bellek_hazir_i = 1'b0;
    chk("sonsuz_hazir", cpu_hazir_o, 1);
    chk("sonsuz_veri", cpu_veri_o, 32'h0BAD_CAFE);
    chk("sonsuz_hata", cpu_hata_o, 0);
`endif
    tick();
    chk("son_hazir", cpu_hazir_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
